// File: rtl/digital_tube_rx.sv
// Receive side of a 4-digit multiplexed 7-segment bus: debounces each scan slot, decodes it
// and emits whole frames. Optional error counter under DIGITAL_TUBE_RX_ERR_CNT_EN.
module digital_tube_rx #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] csn,
    input  logic [6:0] abcdefg,
    output logic [3:0] single_digit,
    output logic [3:0] ten_digit,
    output logic [3:0] hundred_digit,
    output logic [3:0] kilo_digit,
    output logic       frame_vld,
    output logic       seg_err,
    output logic       csn_err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYC);
    localparam logic [7:0]  STAB_ACC = 8'(STABLE_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [3:0]      csn_q, csn_p_q;
    logic [6:0]      seg_q, seg_p_q;
    logic            primed_q;
    logic [7:0]      stab_q, stab_d;
    logic [3:0]      mask_q, mask_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0][3:0] digit_q, digit_d;
    logic            frame_vld_q, frame_vld_d;
    logic            seg_err_q, seg_err_d;
    logic            csn_err_q, csn_err_d;

    logic       onehot, multi, changed, sel, complete, dec_ok;
    logic [3:0] dec_val;

    function automatic logic [4:0] dec7(input logic [6:0] s);
        case (s)
            7'h7E: dec7 = 5'h10; 7'h30: dec7 = 5'h11; 7'h6D: dec7 = 5'h12; 7'h79: dec7 = 5'h13;
            7'h33: dec7 = 5'h14; 7'h5B: dec7 = 5'h15; 7'h5F: dec7 = 5'h16; 7'h70: dec7 = 5'h17;
            7'h7F: dec7 = 5'h18; 7'h7B: dec7 = 5'h19; 7'h77: dec7 = 5'h1A; 7'h1F: dec7 = 5'h1B;
            7'h4E: dec7 = 5'h1C; 7'h3D: dec7 = 5'h1D; 7'h4F: dec7 = 5'h1E; 7'h47: dec7 = 5'h1F;
            default: dec7 = 5'h00;
        endcase
    endfunction

    always_comb begin
        onehot   = ($countones(~csn_q) == 1);
        // The all-zero reset value of csn_q is not a real bus sample; keep it out of csn_err.
        multi    = primed_q && ($countones(~csn_q) >= 2);
        changed  = ({csn_q, seg_q} != {csn_p_q, seg_p_q});
        {dec_ok, dec_val} = dec7(seg_q);
        complete = (mask_q == 4'hF);

        stab_d = stab_q;
        if (changed || !onehot)      stab_d = '0;
        else if (stab_q < STAB_MAX)  stab_d = stab_q + 8'd1;
        // stab_d counts the current cycle, so this fires once per stable period.
        sel = onehot && (stab_d == STAB_ACC);

        mask_d      = complete ? 4'h0 : mask_q;
        shadow_d    = shadow_q;
        digit_d     = complete ? shadow_q : digit_q;
        frame_vld_d = complete;
        seg_err_d   = sel && !dec_ok;
        csn_err_d   = multi;
        tmo_d       = '0;

        if (sel) begin
            mask_d = mask_d | ~csn_q;
            if (dec_ok)
                for (int i = 0; i < 4; i++)
                    if (!csn_q[i]) shadow_d[i] = dec_val;
        end else if (!complete && mask_q != 4'h0) begin
            if (tmo_q == TMO_LAST) mask_d = 4'h0;
            else                   tmo_d  = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            csn_q       <= '0;
            seg_q       <= '0;
            csn_p_q     <= '0;
            seg_p_q     <= '0;
            primed_q    <= 1'b0;
            stab_q      <= '0;
            mask_q      <= '0;
            tmo_q       <= '0;
            shadow_q    <= '0;
            digit_q     <= '0;
            frame_vld_q <= 1'b0;
            seg_err_q   <= 1'b0;
            csn_err_q   <= 1'b0;
        end else begin
            csn_q       <= csn;
            seg_q       <= abcdefg;
            csn_p_q     <= csn_q;
            seg_p_q     <= seg_q;
            primed_q    <= 1'b1;
            stab_q      <= stab_d;
            mask_q      <= mask_d;
            tmo_q       <= tmo_d;
            shadow_q    <= shadow_d;
            digit_q     <= digit_d;
            frame_vld_q <= frame_vld_d;
            seg_err_q   <= seg_err_d;
            csn_err_q   <= csn_err_d;
        end
    end

    assign single_digit  = digit_q[0];
    assign ten_digit     = digit_q[1];
    assign hundred_digit = digit_q[2];
    assign kilo_digit    = digit_q[3];
    assign frame_vld     = frame_vld_q;
    assign seg_err       = seg_err_q;
    assign csn_err       = csn_err_q;

`ifdef DIGITAL_TUBE_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum;

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 9'(seg_err_q) + 9'(csn_err_q);
        err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
